// File: rtl/xmul_row_seq_pkg.sv
// Shared definitions for the extended-multiplier row sequencer: function codes,
// response tag kinds and the sequencer state encoding.
package xmul_row_seq_pkg;

    localparam int XLEN  = 64;
    localparam int TAG_W = 5;
    localparam int FN_W  = 6;

    // These codes must match the multiplier's decoder.
    localparam logic [FN_W-1:0] FN_MADDL = 6'd50;
    localparam logic [FN_W-1:0] FN_MADDH = 6'd51;
    localparam logic [FN_W-1:0] FN_CADD  = 6'd52;

    localparam logic [1:0] KIND_L = 2'b01;
    localparam logic [1:0] KIND_H = 2'b10;
    localparam logic [1:0] KIND_C = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_L,
        S_MUL_H,
        S_WAIT_L,
        S_ADD_C,
        S_WAIT_C,
        S_CAPT,
        S_FIN
    } state_t;

    function automatic logic [TAG_W-1:0] mkTag(input logic [1:0] kind, input logic [2:0] idx);
        return {kind, idx};
    endfunction

endpackage

// File: rtl/xmul_row_seq_if.sv
// Request/response bundle between the row sequencer (master) and the
// fixed-latency extended multiplier (slave).
interface xmul_row_seq_if;
    import xmul_row_seq_pkg::*;

    logic             req_valid;
    logic             req_bits_dw;
    logic [FN_W-1:0]  req_bits_fn;
    logic [TAG_W-1:0] req_bits_tag;
    logic [XLEN-1:0]  req_bits_in1;
    logic [XLEN-1:0]  req_bits_in2;
    logic [XLEN-1:0]  req_in3;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_bits_dw, req_bits_fn, req_bits_tag,
               req_bits_in1, req_bits_in2, req_in3,
        input  resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_bits_dw, req_bits_fn, req_bits_tag,
               req_bits_in1, req_bits_in2, req_in3,
        output resp_data, resp_tag
    );

endinterface

// File: rtl/xmul_row_seq.sv
// Row sequencer: R[0..NLIMBS] = a * B + C using MADDL/MADDH/CADD requests to a
// multiplier whose response arrives exactly two cycles after each request.
module xmul_row_seq
    import xmul_row_seq_pkg::*;
#(
    parameter int NLIMBS = 8
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        i_start,
    input  logic [63:0] i_a,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [2:0]  o_op_idx,
    input  logic [63:0] i_b_limb,
    input  logic [63:0] i_c_limb,
    output logic        o_wr_en,
    output logic [3:0]  o_wr_idx,
    output logic [63:0] o_wr_data,
    xmul_row_seq_if.master mul
);

    localparam logic [2:0] LAST_IDX = 3'(NLIMBS - 1);
    localparam logic [3:0] FIN_IDX  = 4'(NLIMBS);

    state_t      r_state;
    state_t      w_next;
    logic [63:0] r_a;
    logic [63:0] r_b;
    logic [63:0] r_c;
    logic [63:0] r_lo;
    logic [63:0] r_carry;
    logic [2:0]  r_idx;
    logic        r_err;
    logic [63:0] w_sum;
    logic [1:0]  w_expKind;
    logic        w_checkTag;
    logic        w_tagBad;

    assign w_sum    = r_lo + r_carry;
    assign o_err    = r_err;
    assign o_op_idx = r_idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        o_busy           = 1'b1;
        o_done           = 1'b0;
        o_wr_en          = 1'b0;
        o_wr_idx         = '0;
        o_wr_data        = '0;
        mul.req_valid    = 1'b0;
        mul.req_bits_dw  = 1'b0;
        mul.req_bits_fn  = '0;
        mul.req_bits_tag = '0;
        mul.req_bits_in1 = '0;
        mul.req_bits_in2 = '0;
        mul.req_in3      = '0;
        w_expKind        = KIND_L;
        w_checkTag       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) w_next = S_MUL_L;
            end
            S_MUL_L: begin
                mul.req_valid    = 1'b1;
                mul.req_bits_dw  = 1'b1;
                mul.req_bits_fn  = FN_MADDL;
                mul.req_bits_tag = mkTag(KIND_L, r_idx);
                mul.req_bits_in1 = r_a;
                mul.req_bits_in2 = i_b_limb;
                mul.req_in3      = i_c_limb;
                w_next           = S_MUL_H;
            end
            S_MUL_H: begin
                mul.req_valid    = 1'b1;
                mul.req_bits_dw  = 1'b1;
                mul.req_bits_fn  = FN_MADDH;
                mul.req_bits_tag = mkTag(KIND_H, r_idx);
                mul.req_bits_in1 = r_a;
                mul.req_bits_in2 = r_b;
                mul.req_in3      = r_c;
                w_next           = S_WAIT_L;
            end
            S_WAIT_L: begin
                w_expKind  = KIND_L;
                w_checkTag = 1'b1;
                w_next     = S_ADD_C;
            end
            S_ADD_C: begin
                // CADD folds the carry-out of lo+carry into hi, giving the next carry.
                w_expKind        = KIND_H;
                w_checkTag       = 1'b1;
                o_wr_en          = 1'b1;
                o_wr_idx         = {1'b0, r_idx};
                o_wr_data        = w_sum;
                mul.req_valid    = 1'b1;
                mul.req_bits_dw  = 1'b1;
                mul.req_bits_fn  = FN_CADD;
                mul.req_bits_tag = mkTag(KIND_C, r_idx);
                mul.req_bits_in1 = r_lo;
                mul.req_bits_in2 = r_carry;
                mul.req_in3      = mul.resp_data;
                w_next           = S_WAIT_C;
            end
            S_WAIT_C: begin
                w_next = S_CAPT;
            end
            S_CAPT: begin
                w_expKind  = KIND_C;
                w_checkTag = 1'b1;
                w_next     = (r_idx == LAST_IDX) ? S_FIN : S_MUL_L;
            end
            S_FIN: begin
                o_done    = 1'b1;
                o_wr_en   = 1'b1;
                o_wr_idx  = FIN_IDX;
                o_wr_data = r_carry;
                w_next    = S_IDLE;
            end
            default: begin
                o_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    assign w_tagBad = w_checkTag && (mul.resp_tag != mkTag(w_expKind, r_idx));

    // A bad tag only flags the error; the received data is consumed regardless.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_lo    <= '0;
            r_carry <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_tagBad) r_err <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_err   <= 1'b0;
                        r_idx   <= '0;
                        r_carry <= '0;
                    end
                end
                S_MUL_L: begin
                    r_b <= i_b_limb;
                    r_c <= i_c_limb;
                end
                S_WAIT_L: begin
                    r_lo <= mul.resp_data;
                end
                S_CAPT: begin
                    r_carry <= mul.resp_data;
                    if (r_idx != LAST_IDX) r_idx <= r_idx + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xmul_row_seq.sv
// Self-checking bench for xmul_row_seq with a behavioural two-cycle multiplier
// and a 128-bit arithmetic reference for the row result.
module tb_xmul_row_seq;

    localparam int N = 8;
    localparam int ROW_CYCLES = 6 * N + 1;

    typedef struct {
        logic [63:0]        a;
        logic [7:0][63:0]   b;
        logic [7:0][63:0]   c;
        logic [8:0][63:0]   r;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iStart = 1'b0;
    logic [63:0] iA = '0;
    logic        oBusy, oDone, oErr, oWrEn;
    logic [2:0]  oOpIdx;
    logic [3:0]  oWrIdx;
    logic [63:0] oWrData, bLimb, cLimb;

    logic [7:0][63:0] bMem = '0;
    logic [7:0][63:0] cMem = '0;
    logic [8:0][63:0] captured = '0;

    int testsRun = 0;
    int testsFailed = 0;
    int wrCount = 0, reqCount = 0, doneCount = 0, nextWrIdx = 0;
    int orderBad = 0, protoBad = 0;
    logic corruptOn = 1'b0;

    xmul_row_seq_if mulIf();

    xmul_row_seq #(.NLIMBS(N)) dut (
        .clock    (clock),
        .reset    (reset),
        .i_start  (iStart),
        .i_a      (iA),
        .o_busy   (oBusy),
        .o_done   (oDone),
        .o_err    (oErr),
        .o_op_idx (oOpIdx),
        .i_b_limb (bLimb),
        .i_c_limb (cLimb),
        .o_wr_en  (oWrEn),
        .o_wr_idx (oWrIdx),
        .o_wr_data(oWrData),
        .mul      (mulIf.master)
    );

    always #5 clock = ~clock;

    assign bLimb = bMem[oOpIdx];
    assign cLimb = cMem[oOpIdx];

    // Multiplier stand-in: result computed from the request, presented two cycles later.
    function automatic logic [63:0] mulResult(input logic [5:0] fn, input logic [63:0] x,
                                              input logic [63:0] y, input logic [63:0] z);
        logic [127:0] prod;
        logic [64:0]  s;
        prod = {64'd0, x} * {64'd0, y} + {64'd0, z};
        s    = {1'b0, x} + {1'b0, y};
        case (fn)
            6'd50:   return prod[63:0];
            6'd51:   return prod[127:64];
            6'd52:   return z + {63'd0, s[64]};
            default: return 64'd0;
        endcase
    endfunction

    logic [63:0] p1Data, p2Data;
    logic [4:0]  p1Tag, p2Tag;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            p1Data <= '0; p2Data <= '0; p1Tag <= '0; p2Tag <= '0;
        end else begin
            p1Data <= mulIf.req_valid ? mulResult(mulIf.req_bits_fn, mulIf.req_bits_in1,
                                                  mulIf.req_bits_in2, mulIf.req_in3) : 64'd0;
            p1Tag  <= mulIf.req_valid ? mulIf.req_bits_tag : 5'd0;
            p2Data <= p1Data;
            p2Tag  <= p1Tag;
        end
    end

    assign mulIf.resp_data = p2Data;
    assign mulIf.resp_tag  = (corruptOn && p2Tag == 5'b01_010) ? (p2Tag ^ 5'b10000) : p2Tag;

    // Protocol monitor, sampled mid-cycle.
    always @(negedge clock) begin
        #1;
        if (!reset) begin
            if (oWrEn) begin
                captured[oWrIdx] = oWrData;
                if (int'(oWrIdx) != nextWrIdx) orderBad++;
                nextWrIdx++;
                wrCount++;
            end else if (oWrIdx != 4'd0 || oWrData != 64'd0) begin
                protoBad++;
            end
            if (mulIf.req_valid) begin
                reqCount++;
                if (mulIf.req_bits_dw !== 1'b1) protoBad++;
            end else if (mulIf.req_bits_dw || mulIf.req_bits_fn != 0 || mulIf.req_bits_tag != 0 ||
                         mulIf.req_bits_in1 != 0 || mulIf.req_bits_in2 != 0 || mulIf.req_in3 != 0) begin
                protoBad++;
            end
            if (oDone) doneCount++;
        end
    end

    function automatic logic [8:0][63:0] refRow(input logic [63:0] a, input logic [7:0][63:0] b,
                                                 input logic [7:0][63:0] c);
        logic [127:0]     acc;
        logic [63:0]      carry;
        logic [8:0][63:0] r;
        carry = '0;
        for (int i = 0; i < N; i++) begin
            acc   = {64'd0, a} * {64'd0, b[i]} + {64'd0, c[i]} + {64'd0, carry};
            r[i]  = acc[63:0];
            carry = acc[127:64];
        end
        r[8] = carry;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clearCounters();
        wrCount = 0; reqCount = 0; doneCount = 0; nextWrIdx = 0;
        orderBad = 0; protoBad = 0; captured = '0;
    endtask

    task automatic checkRow(input vec_t v, input int expReqs);
        for (int j = 0; j <= N; j++) checkOutput($sformatf("R[%0d]", j), captured[j], v.r[j]);
        checkOutput("write count", 64'(wrCount), 64'(N + 1));
        checkOutput("request count", 64'(reqCount), 64'(expReqs));
        checkOutput("write order", 64'(orderBad), 64'd0);
        checkOutput("idle bus zero", 64'(protoBad), 64'd0);
    endtask

    // Runs one row from the IDLE cycle at the current negedge until done.
    task automatic applyStimulus(input vec_t v, input logic expErr);
        int   k;
        logic seen;
        bMem = v.b; cMem = v.c;
        clearCounters();
        iStart = 1'b1; iA = v.a;
        k = 0; seen = 1'b0;
        while (k < 200 && !seen) begin
            @(negedge clock);
            k++;
            iStart = 1'b0;
            if (k == 1) begin
                checkOutput("busy after start", 64'(oBusy), 64'd1);
                checkOutput("err cleared on start", 64'(oErr), 64'd0);
            end
            if (oDone) seen = 1'b1;
        end
        checkOutput("done latency", 64'(k), 64'(ROW_CYCLES));
        checkOutput("err at done", 64'(oErr), 64'(expErr));
        @(negedge clock);
        checkOutput("done pulses", 64'(doneCount), 64'd1);
        checkOutput("idle after done", 64'(oBusy), 64'd0);
        checkRow(v, 3 * N);
    endtask

    vec_t vecs[9];

    initial begin
        int   k, doneK;
        logic seenDone;

        for (int i = 0; i < N; i++) begin
            vecs[0].b[i] = {$urandom, $urandom};
            vecs[0].c[i] = 64'(i + 1);
            vecs[0].r[i] = 64'(i + 1);
            vecs[1].b[i] = '1;
            vecs[1].c[i] = '1;
            vecs[1].r[i] = (i == 0) ? 64'd0 : '1;
            vecs[2].b[i] = '1;
            vecs[2].c[i] = (i == 0) ? 64'd1 : 64'd0;
            vecs[2].r[i] = 64'd0;
        end
        vecs[0].a = 64'd0; vecs[0].r[8] = 64'd0;
        vecs[1].a = '1;    vecs[1].r[8] = '1;
        vecs[2].a = 64'd1; vecs[2].r[8] = 64'd1;
        for (int t = 3; t < 9; t++) begin
            vecs[t].a = {$urandom, $urandom};
            for (int i = 0; i < N; i++) begin
                vecs[t].b[i] = (t == 8) ? '1 : {$urandom, $urandom};
                vecs[t].c[i] = {$urandom, $urandom};
            end
            vecs[t].r = refRow(vecs[t].a, vecs[t].b, vecs[t].c);
        end

        repeat (2) @(negedge clock);
        checkOutput("reset outputs", {oBusy, oDone, oErr, oWrEn, oOpIdx, oWrIdx, mulIf.req_valid,
                                      mulIf.req_bits_tag, mulIf.req_bits_fn} == '0, 1'b1);
        reset = 1'b0;
        @(negedge clock);

        for (int t = 0; t < 9; t++) applyStimulus(vecs[t], 1'b0);

        // Corrupted low-half tag in limb 2: sticky err, data still used, cleared by next start.
        corruptOn = 1'b1;
        applyStimulus(vecs[1], 1'b1);
        corruptOn = 1'b0;
        applyStimulus(vecs[1], 1'b0);

        // Async reset while limb 3 is in its add/write cycle.
        corruptOn = 1'b1;
        bMem = vecs[4].b; cMem = vecs[4].c;
        iStart = 1'b1; iA = vecs[4].a;
        for (k = 0; k < 22; k++) begin
            @(negedge clock);
            iStart = 1'b0;
        end
        checkOutput("pre-reset write idx", 64'(oWrEn ? oWrIdx : 4'hF), 64'd3);
        checkOutput("pre-reset err", 64'(oErr), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("mid-op reset outputs", 64'({oBusy, oDone, oErr, oWrEn, oOpIdx, oWrIdx,
                    mulIf.req_valid, mulIf.req_bits_dw, mulIf.req_bits_tag, mulIf.req_bits_fn} == '0),
                    64'd1);
        checkOutput("mid-op reset data", oWrData | mulIf.req_bits_in1 | mulIf.req_bits_in2 |
                    mulIf.req_in3, 64'd0);
        corruptOn = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        applyStimulus(vecs[1], 1'b0);

        // Start pulses while busy and during FIN are ignored.
        bMem = vecs[5].b; cMem = vecs[5].c;
        clearCounters();
        iStart = 1'b1; iA = vecs[5].a;
        k = 0; doneK = 0; seenDone = 1'b0;
        while (k < 150 && !(seenDone && k >= doneK + 10)) begin
            @(negedge clock);
            k++;
            if (oDone && !seenDone) begin
                seenDone = 1'b1; doneK = k; iStart = 1'b1;
            end else begin
                iStart = (k == 10 || k == 30);
            end
        end
        checkOutput("busy-start done latency", 64'(doneK), 64'(ROW_CYCLES));
        checkOutput("busy-start done pulses", 64'(doneCount), 64'd1);
        checkOutput("busy-start stays idle", 64'(oBusy), 64'd0);
        checkRow(vecs[5], 3 * N);

        // Start held across FIN is taken on the following IDLE cycle.
        bMem = vecs[6].b; cMem = vecs[6].c;
        clearCounters();
        iStart = 1'b1; iA = vecs[6].a;
        k = 0; doneK = 0;
        while (k < 250 && doneCount < 2) begin
            @(negedge clock);
            k++;
            if (k == ROW_CYCLES + 2) begin
                checkOutput("held start re-accepted", 64'(oBusy), 64'd1);
                iStart = 1'b0;
            end
            if (oDone) doneK = k;
        end
        checkOutput("second done latency", 64'(doneK), 64'(2 * ROW_CYCLES + 1));
        @(negedge clock);
        checkOutput("held start done pulses", 64'(doneCount), 64'd2);
        checkOutput("held start requests", 64'(reqCount), 64'(6 * N));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
